// File: rtl/adrv9001_tx_framer.sv
// ADRV9001 TX SSI framer: buffers {I,Q} samples in a FIFO and serializes
// them as 8-bit serdes words with a strobe, inside a TDD-counted window.
//
// Ports:
//   s_axis_aclk / s_axis_rstn   clock, async active-low reset
//   s_axis_tdata/tvalid/tready  AXI-stream sample input {I[15:0],Q[15:0]}
//   tdd_en                      TDD frame enable (synchronous)
//   enable_cnt / disable_cnt    SSI window bounds on the frame counter
//   i_data / q_data / strobe    serdes words, MSB transmitted first
//   enable / active             TX front-end enable, SSI window open
//   underflow / underflow_cnt   sticky flag, saturating underflow count

module adrv9001_tx_framer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_rstn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        tdd_en,
  input  logic [31:0] enable_cnt,
  input  logic [31:0] disable_cnt,
  output logic [7:0]  i_data,
  output logic [7:0]  q_data,
  output logic [7:0]  strobe,
  output logic        enable,
  output logic        active,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   cnt_q, cnt_d;
  logic          enable_q, enable_d;
  logic          active_q, active_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] fill_q, fill_d;

  logic [31:0]   hold_q, hold_d;
  logic [31:0]   sample_d;
  logic [7:0]    i_data_q, i_data_d;
  logic [7:0]    q_data_q, q_data_d;
  logic [7:0]    strobe_q, strobe_d;
  logic          uf_q, uf_d;
  logic [15:0]   uf_cnt_q, uf_cnt_d;

  logic          tready;
  logic          push;
  logic          pop;
  logic          uf_evt;
  logic          enter_hi;
  logic          nempty;

  // Frame counter and window flags

  always_comb begin
    if (!tdd_en) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  assign enable_d = (cnt_q != '0) && (cnt_q <= disable_cnt);
  assign active_d = (cnt_q > enable_cnt) && (cnt_q <= disable_cnt);

  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      cnt_q    <= '0;
      enable_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      active_q <= active_d;
    end
  end

  // Sample FIFO

  assign tready   = (fill_q < DEPTH_C);
  assign push     = s_axis_tvalid && tready;
  assign nempty   = (fill_q != '0);
  assign enter_hi = (state_d == ST_HI);
  assign pop      = enter_hi && nempty;
  assign uf_evt   = enter_hi && !nempty;

  // The pop reads the registered head, so a same-edge push is never seen.
  assign sample_d = pop ? mem_q[rd_q] : 32'h0;

  assign wr_d = push ? wr_q + AW'(1) : wr_q;
  assign rd_d = pop  ? rd_q + AW'(1) : rd_q;

  always_comb begin
    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      mem_q[wr_q] <= s_axis_tdata;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
    end
  end

  // Serializer FSM: state register

  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Serializer FSM: next state. HI always completes through LO.

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = active_q ? ST_HI : ST_IDLE;
      ST_HI:   state_d = ST_LO;
      ST_LO:   state_d = active_q ? ST_HI : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Serializer FSM: outputs for the state being entered

  always_comb begin
    i_data_d = 8'h00;
    q_data_d = 8'h00;
    strobe_d = 8'h00;
    hold_d   = hold_q;
    unique case (state_d)
      ST_HI: begin
        hold_d   = sample_d;
        i_data_d = sample_d[31:24];
        q_data_d = sample_d[15:8];
        strobe_d = 8'h80;
      end
      ST_LO: begin
        i_data_d = hold_q[23:16];
        q_data_d = hold_q[7:0];
        strobe_d = 8'h00;
      end
      default: begin
        i_data_d = 8'h00;
        q_data_d = 8'h00;
        strobe_d = 8'h00;
      end
    endcase
  end

  // Underflow tracking; a frame stop clears even a same-edge event.

  always_comb begin
    uf_d     = uf_q;
    uf_cnt_d = uf_cnt_q;
    if (!tdd_en) begin
      uf_d     = 1'b0;
      uf_cnt_d = '0;
    end else if (uf_evt) begin
      uf_d = 1'b1;
      if (uf_cnt_q != 16'hFFFF) begin
        uf_cnt_d = uf_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      hold_q   <= '0;
      i_data_q <= '0;
      q_data_q <= '0;
      strobe_q <= '0;
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      hold_q   <= hold_d;
      i_data_q <= i_data_d;
      q_data_q <= q_data_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign s_axis_tready = tready;
  assign i_data        = i_data_q;
  assign q_data        = q_data_q;
  assign strobe        = strobe_q;
  assign enable        = enable_q;
  assign active        = active_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_adrv9001_tx_framer.sv
// Bench for adrv9001_tx_framer: queue-based reference model checked
// every cycle, plus directed literal scenarios and random traffic.

module tb_adrv9001_tx_framer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tdd = 1'b0;
  logic [31:0] en_cnt = 32'd2;
  logic [31:0] dis_cnt = 32'd6;
  logic [7:0]  i_d, q_d, stb;
  logic        en_o, act_o, uf;
  logic [15:0] ufc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  adrv9001_tx_framer #(.FIFO_DEPTH(DEPTH)) dut (
    .s_axis_aclk   (clk),
    .s_axis_rstn   (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .tdd_en        (tdd),
    .enable_cnt    (en_cnt),
    .disable_cnt   (dis_cnt),
    .i_data        (i_d),
    .q_data        (q_d),
    .strobe        (stb),
    .enable        (en_o),
    .active        (act_o),
    .underflow     (uf),
    .underflow_cnt (ufc)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sample queue plus a 3-phase word sequencer
  logic [31:0] mq[$];
  logic [31:0] m_cnt = '0;
  logic [31:0] m_hold = '0;
  int          m_ph = 0;
  bit          m_en = 0;
  bit          m_act = 0;
  bit          m_uf = 0;
  logic [15:0] m_ufc = '0;
  logic [7:0]  m_i = '0, m_q = '0, m_s = '0;

  task automatic mdl_clear();
    mq.delete();
    m_cnt = '0; m_hold = '0; m_ph = 0;
    m_en = 0; m_act = 0; m_uf = 0; m_ufc = '0;
    m_i = '0; m_q = '0; m_s = '0;
  endtask

  task automatic mdl_step();
    int nph;
    logic [31:0] smp;
    bit ev;
    bit push;
    ev = 0;
    smp = '0;
    if (m_ph == 1) nph = 2;
    else nph = m_act ? 1 : 0;
    push = tvalid && (mq.size() < DEPTH);
    if (nph == 1) begin
      if (mq.size() != 0) smp = mq.pop_front();
      else ev = 1;
      m_hold = smp;
      m_i = smp[31:24]; m_q = smp[15:8]; m_s = 8'h80;
    end else if (nph == 2) begin
      m_i = m_hold[23:16]; m_q = m_hold[7:0]; m_s = 8'h00;
    end else begin
      m_i = 8'h00; m_q = 8'h00; m_s = 8'h00;
    end
    if (push) mq.push_back(tdata);
    if (!tdd) begin
      m_uf = 0; m_ufc = '0;
    end else if (ev) begin
      m_uf = 1;
      if (m_ufc != 16'hFFFF) m_ufc = m_ufc + 16'd1;
    end
    m_en  = (m_cnt != 0) && (m_cnt <= dis_cnt);
    m_act = (m_cnt > en_cnt) && (m_cnt <= dis_cnt);
    if (!tdd) m_cnt = '0;
    else if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
    m_ph = nph;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl_clear();
    else mdl_step();
  end

  bit cmp_on = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_i_data", {24'h0, i_d}, {24'h0, m_i});
      chk("m_q_data", {24'h0, q_d}, {24'h0, m_q});
      chk("m_strobe", {24'h0, stb}, {24'h0, m_s});
      chk("m_enable", {31'h0, en_o}, {31'h0, m_en});
      chk("m_active", {31'h0, act_o}, {31'h0, m_act});
      chk("m_uflag", {31'h0, uf}, {31'h0, m_uf});
      chk("m_ucnt", {16'h0, ufc}, {16'h0, m_ufc});
      chk("m_tready", {31'h0, tready}, {31'h0, mq.size() < DEPTH});
    end
  end

  logic [31:0] capw [14];
  bit          cap_en [14];
  bit          cap_act [14];

  task automatic run_cap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      capw[k]    = {8'h0, i_d, q_d, stb};
      cap_en[k]  = en_o;
      cap_act[k] = act_o;
    end
  endtask

  function automatic int cnt_en();
    int c = 0;
    for (int k = 0; k < 14; k++) c += int'(cap_en[k]);
    return c;
  endfunction

  function automatic int cnt_act();
    int c = 0;
    for (int k = 0; k < 14; k++) c += int'(cap_act[k]);
    return c;
  endfunction

  logic [31:0] bp [6];
  int acc;
  int run;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_i", {24'h0, i_d}, 32'h0);
    chk("rst_q", {24'h0, q_d}, 32'h0);
    chk("rst_s", {24'h0, stb}, 32'h0);
    chk("rst_en", {31'h0, en_o}, 32'h0);
    chk("rst_act", {31'h0, act_o}, 32'h0);
    chk("rst_uf", {31'h0, uf}, 32'h0);
    chk("rst_ucnt", {16'h0, ufc}, 32'h0);
    chk("rst_rdy", {31'h0, tready}, 32'h1);
    rst_n = 1'b1;
    cmp_on = 1;
    @(negedge clk);
    chk("rel_rdy", {31'h0, tready}, 32'h1);

    // Nominal framing
    tdata = 32'h1234ABCD; tvalid = 1'b1;
    @(negedge clk);
    tdata = 32'h56789EF0;
    @(negedge clk);
    tvalid = 1'b0;
    en_cnt = 32'd2; dis_cnt = 32'd6; tdd = 1'b1;
    run_cap(14);
    chk("nom_w0", capw[4], 32'h0012AB80);
    chk("nom_w1", capw[5], 32'h0034CD00);
    chk("nom_w2", capw[6], 32'h00569E80);
    chk("nom_w3", capw[7], 32'h0078F000);
    chk("nom_idle", capw[8], 32'h0);
    chk("nom_en0", {31'h0, cap_en[0]}, 32'h0);
    chk("nom_en1", {31'h0, cap_en[1]}, 32'h1);
    chk("nom_encnt", cnt_en(), 32'd6);
    chk("nom_actcnt", cnt_act(), 32'd4);
    chk("nom_uf", {31'h0, uf}, 32'h0);

    // Underflow: same window, empty FIFO
    tdd = 1'b0;
    @(negedge clk);
    tdd = 1'b1;
    run_cap(14);
    chk("uf_w0", capw[4], 32'h00000080);
    chk("uf_w1", capw[5], 32'h0);
    chk("uf_w2", capw[6], 32'h00000080);
    chk("uf_w3", capw[7], 32'h0);
    chk("uf_flag", {31'h0, uf}, 32'h1);
    chk("uf_cnt", {16'h0, ufc}, 32'd2);
    tdd = 1'b0;
    @(negedge clk);
    chk("uf_clr", {31'h0, uf}, 32'h0);
    chk("uf_cclr", {16'h0, ufc}, 32'h0);

    // Backpressure: six offered, four accepted
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      bp[k] = {8'hB0 + 8'(k), 8'hC0 + 8'(k), 8'hD0 + 8'(k), 8'hE0 + 8'(k)};
      tdata = bp[k]; tvalid = 1'b1;
      if (tready) acc++;
      @(negedge clk);
    end
    tvalid = 1'b0;
    chk("bp_acc", acc, 32'd4);
    chk("bp_rdy", {31'h0, tready}, 32'h0);
    tdd = 1'b1;
    run_cap(14);
    chk("bp_first", capw[4], {8'h0, bp[0][31:24], bp[0][15:8], 8'h80});
    tdd = 1'b0;
    @(negedge clk);

    // Mid-sample stop: tdd_en drops on the edge entering HI
    en_cnt = 32'd2; dis_cnt = 32'd20; tdd = 1'b1;
    repeat (4) @(negedge clk);
    tdd = 1'b0;
    @(negedge clk);
    chk("ms_hi", {24'h0, stb}, 32'h80);
    chk("ms_hi_i", {24'h0, i_d}, {24'h0, bp[2][31:24]});
    chk("ms_en_hi", {31'h0, en_o}, 32'h1);
    @(negedge clk);
    chk("ms_lo_i", {24'h0, i_d}, {24'h0, bp[2][23:16]});
    chk("ms_lo_q", {24'h0, q_d}, {24'h0, bp[2][7:0]});
    chk("ms_en_lo", {31'h0, en_o}, 32'h0);
    @(negedge clk);
    chk("ms_idle", {8'h0, i_d, q_d, stb}, 32'h0);

    // Concurrent stream: one push per pop over a 200-cycle window
    tdata = 32'h0BADF00D; tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    en_cnt = 32'd2; dis_cnt = 32'd202; tdd = 1'b1;
    for (int k = 0; k < 215; k++) begin
      tvalid = (k >= 4) && (k <= 202) && (k % 2 == 0);
      tdata = $urandom;
      @(negedge clk);
    end
    tvalid = 1'b0;
    chk("st_uf", {31'h0, uf}, 32'h0);
    chk("st_rdy", {31'h0, tready}, 32'h1);
    tdd = 1'b0;
    @(negedge clk);

    // Random traffic with random windows and a mid-run async reset
    run = 0;
    for (int k = 0; k < 3000; k++) begin
      if (run == 0) begin
        tdd = ~tdd;
        run = $urandom_range(1, 30);
        if (!tdd) begin
          en_cnt = $urandom_range(0, 8);
          dis_cnt = $urandom_range(0, 20);
        end
      end
      run--;
      tvalid = ($urandom_range(0, 1) == 1);
      tdata = $urandom;
      if (k == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_word", {8'h0, i_d, q_d, stb}, 32'h0);
        chk("ar_flags", {29'h0, en_o, act_o, uf}, 32'h0);
        chk("ar_ucnt", {16'h0, ufc}, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_rdy", {31'h0, tready}, 32'h1);
      end
      @(negedge clk);
    end

    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
